// File: rtl/if_id_queue_pkg.sv
// Shared constants and helpers for the IF->ID decoupling queue.
package if_id_queue_pkg;

    // Canonical NOP (addi x0, x0, 0) shown to decode while the queue is empty
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic        BRANCH_NOT_END = 1'b0;
    localparam logic        RST_ENABLE     = 1'b0;

    // Packed entry width: pc + inst + next_pc + next_branch + branch_slot_end
    function automatic int ifq_entry_w(input int addr_w, input int inst_w);
        return 2 * addr_w + inst_w + 2;
    endfunction

endpackage

// File: rtl/if_id_queue_entry_mem.sv
// Entry storage for the IF->ID queue: DEPTH x WIDTH registers, one write
// port and one asynchronous read port. Contents are not reset; the queue's
// occupancy logic guarantees stale slots are never presented downstream.
module if_id_queue_entry_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 98,
    parameter int PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the incoming entry into its slot on an accepted enqueue
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally so decode sees it in the same cycle
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue. Buffers up to DEPTH fetched instructions with
// their pc, predicted next pc, branch hint and slot-end flag, so fetch can
// keep running while decode stalls. Flush and branch redirect empty it.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int PIPE_READY = 1
) (
    input  logic                       clk_i,
    input  logic                       n_rst_i,
    input  logic                       flush_i,
    input  logic                       branch_redirect_i,
    input  logic                       if_valid_i,
    output logic                       if_ready_o,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          next_pc_i,
    input  logic                       next_branch_i,
    input  logic                       branch_slot_end_i,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          next_pc_o,
    output logic                       next_branch_o,
    output logic                       branch_slot_end_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ifq_entry_w(ADDR_W, INST_W);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]  last_pc_q;
    logic [ADDR_W-1:0]  last_next_pc_q;

    logic               empty;
    logic               full;
    logic               flush;
    logic               enq;
    logic               deq;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [ADDR_W-1:0]  head_pc;
    logic [INST_W-1:0]  head_inst;
    logic [ADDR_W-1:0]  head_next_pc;
    logic               head_next_branch;
    logic               head_slot_end;

    // Explicit wrap so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign flush = flush_i | branch_redirect_i;

    // With PIPE_READY a full queue still accepts when the head leaves this cycle
    assign if_ready_o = ~full | ((PIPE_READY != 0) & id_ready_i);
    assign id_valid_o = ~empty;
    assign enq        = if_valid_i & if_ready_o;
    assign deq        = id_valid_o & id_ready_i;
    assign count_o    = count_q;

    assign wr_entry = {pc_i, inst_i, next_pc_i, next_branch_i, branch_slot_end_i};
    assign {head_pc, head_inst, head_next_pc, head_next_branch, head_slot_end} = rd_entry;

    if_id_queue_entry_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_entry_mem (
        .clk_i (clk_i),
        .we    (enq & ~flush),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Pointers, occupancy and last-dequeued pc; flush wins over a same-cycle enq/deq
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (n_rst_i == RST_ENABLE) begin
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            last_pc_q      <= '0;
            last_next_pc_q <= '0;
        end else if (flush) begin
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            last_pc_q      <= '0;
            last_next_pc_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_q       <= ptr_inc(rd_ptr_q);
                last_pc_q      <= head_pc;
                last_next_pc_q <= head_next_pc;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Present the head entry, or NOP with the last dequeued pc while empty
    always_comb begin
        pc_o              = last_pc_q;
        next_pc_o         = last_next_pc_q;
        inst_o            = INST_W'(NOP_INST);
        next_branch_o     = 1'b0;
        branch_slot_end_o = BRANCH_NOT_END;
        if (!empty) begin
            pc_o              = head_pc;
            next_pc_o         = head_next_pc;
            inst_o            = head_inst;
            next_branch_o     = head_next_branch;
            branch_slot_end_o = head_slot_end;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: two instances (DEPTH=2/PIPE_READY=1 and
// DEPTH=3/PIPE_READY=0) share one stimulus stream; each has its own FIFO model.
module tb_if_id_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] npc;
        logic        nb;
        logic        se;
    } ent_t;

    logic        clk;
    logic        n_rst;
    logic        flush;
    logic        redirect;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic [31:0] npc_in;
    logic        nb_in;
    logic        se_in;

    logic        if_ready_w [2];
    logic        id_valid_w [2];
    logic [31:0] pc_w       [2];
    logic [31:0] inst_w     [2];
    logic [31:0] npc_w      [2];
    logic        nb_w       [2];
    logic        se_w       [2];
    logic [1:0]  cnt_w      [2];

    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 0;
    logic [31:0] pc_seq = 32'h0000_0200;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [31:0] last_pc  [2];
    logic [31:0] last_npc [2];

    if_id_queue #(.DEPTH(2), .ADDR_W(32), .INST_W(32), .PIPE_READY(1)) u_dut0 (
        .clk_i(clk), .n_rst_i(n_rst), .flush_i(flush), .branch_redirect_i(redirect),
        .if_valid_i(if_valid), .if_ready_o(if_ready_w[0]),
        .pc_i(pc_in), .inst_i(inst_in), .next_pc_i(npc_in),
        .next_branch_i(nb_in), .branch_slot_end_i(se_in),
        .id_valid_o(id_valid_w[0]), .id_ready_i(id_ready),
        .pc_o(pc_w[0]), .inst_o(inst_w[0]), .next_pc_o(npc_w[0]),
        .next_branch_o(nb_w[0]), .branch_slot_end_o(se_w[0]), .count_o(cnt_w[0])
    );

    if_id_queue #(.DEPTH(3), .ADDR_W(32), .INST_W(32), .PIPE_READY(0)) u_dut1 (
        .clk_i(clk), .n_rst_i(n_rst), .flush_i(flush), .branch_redirect_i(redirect),
        .if_valid_i(if_valid), .if_ready_o(if_ready_w[1]),
        .pc_i(pc_in), .inst_i(inst_in), .next_pc_i(npc_in),
        .next_branch_i(nb_in), .branch_slot_end_i(se_in),
        .id_valid_o(id_valid_w[1]), .id_ready_i(id_ready),
        .pc_o(pc_w[1]), .inst_o(inst_w[1]), .next_pc_o(npc_w[1]),
        .next_branch_o(nb_w[1]), .branch_slot_end_o(se_w[1]), .count_o(cnt_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit pipe_ready(input int d);
        return (d == 0);
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t q_head(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_push(input int d, input ent_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic q_pop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic model_clear(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
        last_pc[d]  = 32'h0;
        last_npc[d] = 32'h0;
    endtask

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Monitor: compare every cycle against the model, pop on each handshake
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                int   sz;
                ent_t h;
                sz = q_size(d);
                chk("count", d, 32'(cnt_w[d]), 32'(sz));
                chk("id_valid", d, 32'(id_valid_w[d]), 32'(sz > 0));
                chk("if_ready", d, 32'(if_ready_w[d]),
                    32'((sz < dep(d)) || (pipe_ready(d) && id_ready)));
                if (id_valid_w[d]) begin
                    if (sz == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL phantom_entry dut%0d: got valid output expected empty at %0t", d, $time);
                    end else begin
                        h = q_head(d);
                        chk("head_pc", d, pc_w[d], h.pc);
                        chk("head_inst", d, inst_w[d], h.inst);
                        chk("head_npc", d, npc_w[d], h.npc);
                        chk("head_nb", d, 32'(nb_w[d]), 32'(h.nb));
                        chk("head_se", d, 32'(se_w[d]), 32'(h.se));
                        if (id_ready) begin
                            q_pop(d);
                            last_pc[d]  = h.pc;
                            last_npc[d] = h.npc;
                        end
                    end
                end else begin
                    chk("empty_inst", d, inst_w[d], 32'h0000_0013);
                    chk("empty_pc", d, pc_w[d], last_pc[d]);
                    chk("empty_npc", d, npc_w[d], last_npc[d]);
                    chk("empty_nb", d, 32'(nb_w[d]), 32'h0);
                    chk("empty_se", d, 32'(se_w[d]), 32'h0);
                end
            end
        end
    end

    // One clock of stimulus; the model commits right after the edge
    task automatic step(input logic v, input logic r, input logic fl, input logic rd,
                        input logic [31:0] pc);
        ent_t e;
        bit   enq [2];
        e.pc  = pc;
        e.inst = $urandom;
        e.npc = $urandom;
        e.nb  = 1'($urandom_range(0, 1));
        e.se  = 1'($urandom_range(0, 1));
        if_valid = v;
        id_ready = r;
        flush    = fl;
        redirect = rd;
        pc_in    = e.pc;
        inst_in  = e.inst;
        npc_in   = e.npc;
        nb_in    = e.nb;
        se_in    = e.se;
        for (int d = 0; d < 2; d++) begin
            enq[d] = v && ((q_size(d) < dep(d)) || (pipe_ready(d) && r));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (fl || rd) model_clear(d);
            else if (enq[d]) q_push(d, e);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_id_valid"}, d, 32'(id_valid_w[d]), 32'h0);
            chk({tag, "_inst"}, d, inst_w[d], 32'h0000_0013);
            chk({tag, "_pc"}, d, pc_w[d], 32'h0);
            chk({tag, "_npc"}, d, npc_w[d], 32'h0);
            chk({tag, "_if_ready"}, d, 32'(if_ready_w[d]), 32'h1);
            chk({tag, "_count"}, d, 32'(cnt_w[d]), 32'h0);
        end
    endtask

    // Assert reset between edges and check the outputs respond without a clock
    task automatic async_reset();
        if_valid = 1'b0;
        flush    = 1'b0;
        redirect = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_clear(0);
        model_clear(1);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst    = 1'b0;
        flush    = 1'b0;
        redirect = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b0;
        pc_in    = '0;
        inst_in  = '0;
        npc_in   = '0;
        nb_in    = 1'b0;
        se_in    = 1'b0;
        model_clear(0);
        model_clear(1);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        n_rst  = 1'b1;
        mon_en = 1'b1;

        // Idle
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Fill with decode stalled: DEPTH=2 takes two, refuses the third
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
        chk("full_ready", 0, 32'(if_ready_w[0]), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h108);
        chk("full_count", 0, 32'(cnt_w[0]), 32'h2);
        chk("full_head_pc", 0, pc_w[0], 32'h100);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_head_pc", 0, pc_w[0], 32'h100);

        // Full with decode ready: 0x108 enters while 0x100 leaves
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h108);
        chk("pipe_count", 0, 32'(cnt_w[0]), 32'h2);
        chk("pipe_head_pc", 0, pc_w[0], 32'h104);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("drain_head_pc", 0, pc_w[0], 32'h108);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect on a full queue drops everything including the new fetch
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h300);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h304);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h308);
        chk("redir_count", 0, 32'(cnt_w[0]), 32'h0);
        chk("redir_valid", 0, 32'(id_valid_w[0]), 32'h0);
        chk("redir_inst", 0, inst_w[0], 32'h0000_0013);
        chk("redir_pc", 0, pc_w[0], 32'h0);

        // Flush and redirect together, with a same-cycle dequeue
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h400);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h404);
        chk("flush_count", 1, 32'(cnt_w[1]), 32'h0);
        chk("flush_ready", 1, 32'(if_ready_w[1]), 32'h1);

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic r;
            logic fl;
            logic rd;
            v  = ($urandom_range(0, 99) < 70);
            r  = ($urandom_range(0, 99) < 55);
            fl = ($urandom_range(0, 99) < 3);
            rd = ($urandom_range(0, 99) < 3);
            if (i == 200) async_reset();
            step(v, r, fl, rd, pc_seq);
            pc_seq = pc_seq + 32'd4;
        end

        // Drain
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        mon_en = 1'b0;
        chk("final_count0", 0, 32'(cnt_w[0]), 32'h0);
        chk("final_count1", 1, 32'(cnt_w[1]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
